// File: rtl/cache_pkg.sv
// Shared constants and FSM state encoding for the set-associative cache.
package cache_pkg;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_e;
endpackage

// File: rtl/lru_tracker.sv
// Per-set LRU age update: the accessed way becomes youngest and every way
// younger than its old age is pushed one step older.
module lru_tracker #(
  parameter int WAYS  = 4,
  parameter int AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] age_i,
  input  logic [AGE_W-1:0]           way_i,
  output logic [WAYS-1:0][AGE_W-1:0] age_o
);
  logic [AGE_W-1:0] old_age;
  assign old_age = age_i[way_i];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    always_comb begin
      age_o[w] = age_i[w];
      if (way_i == AGE_W'(w))    age_o[w] = '0;
      else if (age_i[w] < old_age) age_o[w] = age_i[w] + 1'b1;
    end
  end
endmodule

// File: rtl/assoc_cache.sv
// Write-back, write-allocate set-associative cache, one word per line, LRU
// replacement. Define CACHE_STATS_EN to enable saturating hit/miss counters.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int WAYS   = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              hit_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

  state_e            state;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  ages_t             age_q   [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [WAY_W-1:0]  vic_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              unused_offset;
  assign idx = addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
  assign tag = addr_i[ADDR_W-1:IDX_W+OFFSET_W];
  assign unused_offset = ^addr_i[OFFSET_W-1:0];

  logic             hit, vic_dirty;
  logic [WAY_W-1:0] hit_way, vic_way, acc_way;

  // Victim: lowest invalid way wins, otherwise the way holding the oldest age.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    for (int w = 0; w < WAYS; w++)
      if (age_q[idx][w] == WAY_W'(WAYS-1)) vic_way = WAY_W'(w);
    for (int w = WAYS-1; w >= 0; w--)
      if (!valid_q[idx][w]) vic_way = WAY_W'(w);
  end

  assign vic_dirty = valid_q[idx][vic_way] && dirty_q[idx][vic_way];
  assign acc_way   = (state != IDLE) ? vic_q : (hit ? hit_way : vic_way);

  logic              line_we, tag_we, lru_upd, line_dirty;
  logic [DATA_W-1:0] line_data;

  always_comb begin
    line_we    = 1'b0;
    tag_we     = 1'b0;
    lru_upd    = 1'b0;
    line_dirty = 1'b1;
    line_data  = wdata_i;
    case (state)
      IDLE: if (req_i) begin
        if (hit) begin
          line_we = we_i;
          lru_upd = 1'b1;
        end else if (!vic_dirty && we_i) begin
          line_we = 1'b1;
          tag_we  = 1'b1;
          lru_upd = 1'b1;
        end
      end
      WRITEBACK: if (mem_ack_i && we_i) begin
        line_we = 1'b1;
        tag_we  = 1'b1;
        lru_upd = 1'b1;
      end
      REFILL: if (mem_ack_i) begin
        line_we    = 1'b1;
        tag_we     = 1'b1;
        lru_upd    = 1'b1;
        line_dirty = 1'b0;
        line_data  = mem_rdata_i;
      end
      default: ;
    endcase
  end

  ages_t age_nxt;
  lru_tracker #(.WAYS(WAYS), .AGE_W(WAY_W)) u_lru (
    .age_i (age_q[idx]),
    .way_i (acc_way),
    .age_o (age_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      vic_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (line_we) dirty_q[idx][acc_way] <= line_dirty;
      if (tag_we)  valid_q[idx][acc_way] <= 1'b1;
      if (lru_upd) age_q[idx]            <= age_nxt;
      case (state)
        IDLE: if (req_i && !hit) begin
          vic_q <= vic_way;
          if (vic_dirty)  state <= WRITEBACK;
          else if (we_i)  state <= RESPOND;
          else            state <= REFILL;
        end
        WRITEBACK: if (mem_ack_i) state <= we_i ? RESPOND : REFILL;
        REFILL:    if (mem_ack_i) state <= RESPOND;
        RESPOND:   state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Line payload carries no reset; valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if (line_we) data_q[idx][acc_way] <= line_data;
    if (tag_we)  tag_q[idx][acc_way]  <= tag;
  end

  assign hit_o       = (state == IDLE) && req_i && hit;
  assign ready_o     = hit_o || (state == RESPOND);
  assign rdata_o     = (state == RESPOND) ? data_q[idx][vic_q] : data_q[idx][hit_way];
  assign mem_req_o   = (state == WRITEBACK) || (state == REFILL);
  assign mem_we_o    = (state == WRITEBACK);
  assign mem_wdata_o = data_q[idx][vic_q];
  assign mem_addr_o  = (state == WRITEBACK) ? {tag_q[idx][vic_q], idx, {OFFSET_W{1'b0}}}
                                            : {addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (ready_o) begin
      if (hit_o && hit_cnt != '1)    hit_cnt  <= hit_cnt + 1'b1;
      if (!hit_o && miss_cnt != '1)  miss_cnt <= miss_cnt + 1'b1;
    end
  end
  assign hit_count_o  = hit_cnt;
  assign miss_count_o = miss_cnt;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif
endmodule
